// File: rtl/hazard_stall_controller_if.sv
// Hazard-unit bundle: pipeline-stage register addresses and control in, stall/bubble control out.
// master = pipeline side (drives stage info), slave = hazard controller.
interface hazard_stall_controller_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] ID_RS1addr_i;
    logic [ADDR_W-1:0] ID_RS2addr_i;
    logic              ID_UsesRS1_i;
    logic              ID_UsesRS2_i;
    logic              ID_Branch_i;
    logic [ADDR_W-1:0] EX_RDaddr_i;
    logic              EX_RegWrite_i;
    logic              EX_MemRead_i;
    logic [ADDR_W-1:0] MEM_RDaddr_i;
    logic              MEM_MemRead_i;
    logic              DMem_Stall_i;
    logic              PCWrite_o;
    logic              Stall_o;
    logic              NoOp_o;
    logic              Freeze_o;
    logic [CNT_W-1:0]  StallCnt_o;

    modport master (
        output ID_RS1addr_i, ID_RS2addr_i, ID_UsesRS1_i, ID_UsesRS2_i, ID_Branch_i,
               EX_RDaddr_i, EX_RegWrite_i, EX_MemRead_i, MEM_RDaddr_i, MEM_MemRead_i,
               DMem_Stall_i,
        input  PCWrite_o, Stall_o, NoOp_o, Freeze_o, StallCnt_o
    );

    modport slave (
        input  ID_RS1addr_i, ID_RS2addr_i, ID_UsesRS1_i, ID_UsesRS2_i, ID_Branch_i,
               EX_RDaddr_i, EX_RegWrite_i, EX_MemRead_i, MEM_RDaddr_i, MEM_MemRead_i,
               DMem_Stall_i,
        output PCWrite_o, Stall_o, NoOp_o, Freeze_o, StallCnt_o
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-in-ID hazard detection with multi-cycle stall sequencing,
// data-memory freeze priority and a saturating bubble-cycle counter.
module hazard_stall_controller #(
    parameter int ADDR_W       = 5,
    parameter int LOAD_LAT     = 1,
    parameter int BRANCH_IN_ID = 1,
    parameter int CNT_W        = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    hazard_stall_controller_if.slave  bus
);
    localparam int REM_W = $clog2(LOAD_LAT + 2);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_STALL = 1'b1;

    localparam logic [REM_W-1:0] N_ONE  = REM_W'(1);
    localparam logic [REM_W-1:0] N_LAT  = REM_W'(LOAD_LAT);
    localparam logic [REM_W-1:0] N_LAT1 = REM_W'(LOAD_LAT + 1);

    localparam bit BR_EN = (BRANCH_IN_ID != 0);

    logic [0:0]       state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REM_W-1:0] hazard_n;
    logic             pc_write, stall, noop, freeze;

    // An operand matches a producer only if it is really read and the producer is not x0.
    logic ex_match, mem_match;
    assign ex_match =
        (bus.EX_RDaddr_i != '0) &&
        ((bus.ID_UsesRS1_i && (bus.ID_RS1addr_i == bus.EX_RDaddr_i)) ||
         (bus.ID_UsesRS2_i && (bus.ID_RS2addr_i == bus.EX_RDaddr_i)));
    assign mem_match =
        (bus.MEM_RDaddr_i != '0) &&
        ((bus.ID_UsesRS1_i && (bus.ID_RS1addr_i == bus.MEM_RDaddr_i)) ||
         (bus.ID_UsesRS2_i && (bus.ID_RS2addr_i == bus.MEM_RDaddr_i)));

    logic branch_hz;
    assign branch_hz = BR_EN && bus.ID_Branch_i;

    // Bubble count for the hazard seen in ID; the longest requirement wins.
    always_comb begin
        hazard_n = '0;
        if (bus.EX_MemRead_i && ex_match) begin
            hazard_n = N_LAT;
        end
        if (branch_hz && bus.MEM_MemRead_i && mem_match && (hazard_n < N_LAT)) begin
            hazard_n = N_LAT;
        end
        if (branch_hz && bus.EX_RegWrite_i && !bus.EX_MemRead_i && ex_match && (hazard_n < N_ONE)) begin
            hazard_n = N_ONE;
        end
        if (branch_hz && bus.EX_MemRead_i && ex_match) begin
            hazard_n = N_LAT1;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        pc_write = 1'b1;
        stall    = 1'b0;
        noop     = 1'b0;
        freeze   = 1'b0;
        if (rst_i) begin
            pc_write = 1'b1;
        end else if (bus.DMem_Stall_i) begin
            freeze   = 1'b1;
            pc_write = 1'b0;
            stall    = 1'b1;
        end else if (state_q == S_STALL) begin
            pc_write = 1'b0;
            stall    = 1'b1;
            noop     = 1'b1;
            if (rem_q == N_ONE) begin
                state_d = S_IDLE;
                rem_d   = '0;
            end else begin
                rem_d = rem_q - N_ONE;
            end
        end else if (hazard_n != '0) begin
            pc_write = 1'b0;
            stall    = 1'b1;
            noop     = 1'b1;
            if (hazard_n > N_ONE) begin
                state_d = S_STALL;
                rem_d   = hazard_n - N_ONE;
            end
        end
    end

    assign cnt_d = (noop && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.PCWrite_o  = pc_write;
    assign bus.Stall_o    = stall;
    assign bus.NoOp_o     = noop;
    assign bus.Freeze_o   = freeze;
    assign bus.StallCnt_o = cnt_q;
endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Parametrised hazard detection and stall sequencing for the 5-stage RISC-V pipeline, instantiated at the IF/ID boundary and driving the PC, IF/ID and ID/EX control. It generalises load-use detection with x0 filtering, per-operand use qualification, configurable data-memory load latency (multi-cycle stalls), optional branch-in-ID hazards and a data-memory freeze input. It also keeps a saturating stall-cycle counter for performance reporting.

## Interface
- ADDR_W, 5, register address width
- LOAD_LAT, 1, cycles a load needs after entering MEM before its data can be forwarded; ≥1
- BRANCH_IN_ID, 1, 1 = detect hazards for branches resolved in ID; 0 = branch inputs ignored
- CNT_W, 16, width of the stall-cycle counter

- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- ID_RS1addr_i / ID_RS2addr_i  in  ADDR_W  source registers of the instruction in ID
- ID_UsesRS1_i / ID_UsesRS2_i  in  1  the ID instruction actually reads RS1 / RS2
- ID_Branch_i  in  1  ID instruction is a branch compared in ID
- EX_RDaddr_i  in  ADDR_W  destination of the instruction in EX
- EX_RegWrite_i, EX_MemRead_i  in  1  EX instruction writes rd / is a load
- MEM_RDaddr_i  in  ADDR_W  destination of the instruction in MEM
- MEM_MemRead_i  in  1  MEM instruction is a load
- DMem_Stall_i  in  1  data memory busy; the whole pipeline must freeze
- PCWrite_o  out  1  PC update enable
- Stall_o  out  1  hold IF/ID
- NoOp_o  out  1  insert a bubble into ID/EX
- Freeze_o  out  1  hold every pipeline register (equals DMem_Stall_i outside reset)
- StallCnt_o  out  CNT_W  count of bubble cycles, saturating

## Operation
- Match(a, rd): the operand is used, rd ≠ 0, and a == rd.
- Hazard sources, evaluated in IDLE only. When several apply, N is the largest value:
  - Load-use: EX_MemRead_i and Match on RS1 or RS2 against EX_RDaddr_i. N = LOAD_LAT.
  - Branch-on-ALU (BRANCH_IN_ID=1): ID_Branch_i, EX_RegWrite_i, not EX_MemRead_i, Match against EX_RDaddr_i. N = 1.
  - Branch-on-load-in-EX (BRANCH_IN_ID=1): ID_Branch_i, EX_MemRead_i, Match against EX. N = LOAD_LAT+1.
  - Branch-on-load-in-MEM (BRANCH_IN_ID=1): ID_Branch_i, MEM_MemRead_i, Match against MEM_RDaddr_i. N = LOAD_LAT.
- The FSM has two states, IDLE and STALL. A remaining-cycles register rem is sized to hold LOAD_LAT+1.
- IDLE with a hazard and no freeze:
  - Assert Stall_o=1, NoOp_o=1, PCWrite_o=0 combinationally in the same cycle.
  - If N>1, move to STALL with rem=N-1. Otherwise stay in IDLE.
- In STALL:
  - Outputs are asserted as above. Hazard inputs are ignored.
  - Each non-frozen cycle: if rem==1, go to IDLE; otherwise decrement rem.
- No hazard, or after the stall ends: PCWrite_o=1, Stall_o=0, NoOp_o=0.
- Freeze (DMem_Stall_i=1) has priority in either state:
  - Freeze_o=1, PCWrite_o=0, Stall_o=1, NoOp_o=0.
  - State and rem hold. No new hazard is latched.
  - In IDLE, detection re-evaluates the cycle after the freeze drops.
- StallCnt_o increments by 1 on every clock edge where NoOp_o=1. It holds at 2^CNT_W−1 once reached.
- Reset (rst_i=1 at an edge): state=IDLE, rem=0, StallCnt_o=0. This also applies mid-stall.
- While rst_i is high, combinational outputs are forced to PCWrite_o=1, Stall_o=0, NoOp_o=0, Freeze_o=0.

## Timing
- Detection-to-output latency is 0 cycles (combinational). The FSM updates at the next edge.
- Total bubble cycles per hazard are exactly N, plus the number of frozen cycles inside the stall window.
- A new hazard can be detected at the earliest on the first IDLE cycle after STALL exits. There is no gap cycle requirement.
- Outputs are glitch-tolerant only. Consumers sample them at clk_i edges.
- The BRANCH_IN_ID=0 build must produce identical outputs for any ID_Branch_i value.

## Test plan
- Load-use, LOAD_LAT=1: EX_MemRead=1, EX_RD=5, ID_RS1=5, UsesRS1=1 -> a single cycle of PCWrite=0, Stall=1, NoOp=1, then release; StallCnt=1.
- LOAD_LAT=3, same stimulus held -> exactly 3 bubble cycles (IDLE→STALL rem=2→rem=1→IDLE); StallCnt=3. With EX_RD=0 or UsesRS1=0 -> no stall.
- BRANCH_IN_ID=1, LOAD_LAT=2: ID_Branch=1, EX_MemRead=1, EX_RD=7, ID_RS2=7 -> 3 bubbles. ALU producer (EX_RegWrite=1, MemRead=0) -> 1 bubble. Load in MEM, MEM_RD=7 -> 2 bubbles.
- Freeze inside a stall: LOAD_LAT=3, DMem_Stall_i=1 for 2 cycles during STALL -> Freeze=1, NoOp=0 on those cycles, rem held; 5 stall-window cycles total, StallCnt=3.
- Reset mid-stall: LOAD_LAT=3, rst_i=1 on the second bubble cycle -> the next cycle is IDLE with PCWrite=1, Stall=0, NoOp=0, StallCnt=0.
- Saturation: CNT_W=2 with 5 consecutive single-cycle load-use hazards -> StallCnt sequence 1,2,3,3,3.
